mdio_controller: RTL

MDIO_CONTROLLER -- requirements
Module: mdio_controller

---
 rtl/mdio_controller_if.sv | 23 ++
 rtl/mdio_controller.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mdio_controller_if.sv
// MDIO management port bundle: request/frame inputs from the host side,
// serial MDC/MDIO lines and read-back results from the controller side.
interface mdio_controller_if;
   logic        mdio_start;
   logic [31:0] t_data;
   logic        mdio_in;
   logic        mdc;
   logic        mdio_oe;
   logic        mdio_out;
   logic [15:0] rd_data;
   logic        data_rdy;
   logic        busy;

   modport master (
      output mdio_start, t_data, mdio_in,
      input  mdc, mdio_oe, mdio_out, rd_data, data_rdy, busy
   );

   modport slave (
      input  mdio_start, t_data, mdio_in,
      output mdc, mdio_oe, mdio_out, rd_data, data_rdy, busy
   );
endinterface

// File: rtl/mdio_controller.sv
// MDIO (clause 22) frame engine: shifts a 32-bit frame out MSB first at CLK/2
// and, for reads, captures the 16-bit data phase from the PHY.
module mdio_controller (
   input logic              clk,
   input logic              rst,
   mdio_controller_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SHIFT_OUT = 2'd1,
      SHIFT_IN  = 2'd2,
      DONE      = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] frame_q, frame_d;
   logic [15:0] shreg_q, shreg_d;
   logic [15:0] rd_data_q, rd_data_d;
   logic        mdc_q, mdc_d;
   logic        oe_q, oe_d;
   logic        out_q, out_d;
   logic        busy_q, busy_d;
   logic        rdy_q, rdy_d;

   logic [4:0]  cnt_inc_s;
   logic [15:0] shreg_in_s;
   logic        is_read_s;

   function automatic logic frame_ok(input logic [31:0] f);
      return (f[31:30] == 2'b01) && ((f[29:28] == 2'b01) || (f[29:28] == 2'b10));
   endfunction

   assign cnt_inc_s  = cnt_q + 5'd1;
   assign shreg_in_s = {shreg_q[14:0], bus.mdio_in};
   assign is_read_s  = (frame_q[29:28] == 2'b10);

   // State and output registers, all cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 5'd0;
         frame_q   <= 32'd0;
         shreg_q   <= 16'd0;
         rd_data_q <= 16'd0;
         mdc_q     <= 1'b0;
         oe_q      <= 1'b0;
         out_q     <= 1'b0;
         busy_q    <= 1'b0;
         rdy_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         frame_q   <= frame_d;
         shreg_q   <= shreg_d;
         rd_data_q <= rd_data_d;
         mdc_q     <= mdc_d;
         oe_q      <= oe_d;
         out_q     <= out_d;
         busy_q    <= busy_d;
         rdy_q     <= rdy_d;
      end
   end

   // Next-state and next-output logic; each bit is an MDC-low then MDC-high cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      frame_d   = frame_q;
      shreg_d   = shreg_q;
      rd_data_d = rd_data_q;
      mdc_d     = mdc_q;
      oe_d      = oe_q;
      out_d     = out_q;
      busy_d    = busy_q;
      rdy_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.mdio_start && frame_ok(bus.t_data)) begin
               state_d = SHIFT_OUT;
               frame_d = bus.t_data;
               cnt_d   = 5'd0;
               mdc_d   = 1'b0;
               oe_d    = 1'b1;
               out_d   = bus.t_data[31];
               busy_d  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end

         SHIFT_OUT: begin
            if (!mdc_q) begin
               mdc_d = 1'b1;
            end else if (cnt_q == 5'd31) begin
               state_d = DONE;
               mdc_d   = 1'b0;
               oe_d    = 1'b0;
               out_d   = 1'b0;
               busy_d  = 1'b0;
            end else begin
               mdc_d = 1'b0;
               cnt_d = cnt_inc_s;
               // A read releases the line after the first 16 bits (ST/OP/PHYAD/REGAD/TA).
               if (is_read_s && (cnt_q == 5'd15)) begin
                  state_d = SHIFT_IN;
                  oe_d    = 1'b0;
                  out_d   = 1'b0;
               end else begin
                  out_d = frame_q[5'd31 - cnt_inc_s];
               end
            end
         end

         SHIFT_IN: begin
            if (!mdc_q) begin
               mdc_d = 1'b1;
            end else begin
               mdc_d   = 1'b0;
               shreg_d = shreg_in_s;
               if (cnt_q == 5'd31) begin
                  state_d   = DONE;
                  busy_d    = 1'b0;
                  rd_data_d = shreg_in_s;
                  rdy_d     = 1'b1;
               end else begin
                  cnt_d = cnt_inc_s;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
            cnt_d   = 5'd0;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.mdc      = mdc_q;
   assign bus.mdio_oe  = oe_q;
   assign bus.mdio_out = out_q;
   assign bus.busy     = busy_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.data_rdy = rdy_q;

endmodule
